// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with mid-bit sampling and valid/ready output
module uart_rx_byte #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int DIVISOR  = (CLK_FREQ + BAUD / 2) / BAUD,
  parameter int HALF     = DIVISOR / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic          rx_meta_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          tick;

  assign tick = (baud_q == '0);

  always_comb begin
    state_d     = state_q;
    baud_d      = (baud_q != '0) ? baud_q - ONE : baud_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    if (valid_q && ready_i) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          baud_d  = HALF_LD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            baud_d    = DIV_LD;
            bit_idx_d = 3'd0;
            state_d   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          baud_d  = DIV_LD;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
            // A byte may load in the same cycle the previous one is accepted.
            if (!valid_q || ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule
